// File: rtl/traffic_safety_monitor_if.sv
// Lamp bus between the traffic light controller, the safety monitor and the lamp drivers.
// The controller side (master) drives the raw lamp codes and the acknowledge.
// The monitor side (slave) drives the checked lamp codes and the fault status.
interface traffic_safety_monitor_if;
    logic [1:0] NS_IN;
    logic [1:0] SN_IN;
    logic [1:0] EW_IN;
    logic [1:0] WE_IN;
    logic       FAULT_ACK;
    logic [1:0] NS;
    logic [1:0] SN;
    logic [1:0] EW;
    logic [1:0] WE;
    logic       FAULT;
    logic [2:0] FAULT_CODE;
    logic       BLINK;

    modport master (
        output NS_IN, SN_IN, EW_IN, WE_IN, FAULT_ACK,
        input  NS, SN, EW, WE, FAULT, FAULT_CODE, BLINK
    );

    modport slave (
        input  NS_IN, SN_IN, EW_IN, WE_IN, FAULT_ACK,
        output NS, SN, EW, WE, FAULT, FAULT_CODE, BLINK
    );
endinterface

// File: rtl/traffic_safety_monitor.sv
// Traffic safety monitor: registers the controller lamp codes through to the lamps
// and checks every cycle for conflicting greens, illegal codes, illegal colour
// sequences, short yellows and stuck greens. Any violation latches a fault,
// forces all lamps red and blinks until acknowledged while the controller is all-red.
// Signal order inside the per-signal arrays: 0 = NS, 1 = SN, 2 = EW, 3 = WE.
module traffic_safety_monitor #(
    parameter int MIN_YELLOW = 2,
    parameter int MAX_GREEN  = 16,
    parameter int BLINK_HALF = 4
) (
    input logic                     CLK,
    input logic                     CLEAR,
    traffic_safety_monitor_if.slave bus
);

    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int GW = $clog2(MAX_GREEN + 1);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [YW-1:0] Y_LIMIT = YW'(MIN_YELLOW);
    localparam logic [GW-1:0] G_LIMIT = GW'(MAX_GREEN);
    localparam logic [BW-1:0] B_LAST  = BW'(BLINK_HALF - 1);

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;
    localparam logic [1:0] LAMP_BAD    = 2'b11;

    localparam logic [2:0] CAUSE_NONE     = 3'b000;
    localparam logic [2:0] CAUSE_CONFLICT = 3'b001;
    localparam logic [2:0] CAUSE_ILLEGAL  = 3'b010;
    localparam logic [2:0] CAUSE_SEQUENCE = 3'b011;
    localparam logic [2:0] CAUSE_SHORT_Y  = 3'b100;
    localparam logic [2:0] CAUSE_STUCK_G  = 3'b101;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t          state;
    logic [1:0]      in_code   [4];
    logic [1:0]      prev_code [4];
    logic [1:0]      lamp_q    [4];
    logic [YW-1:0]   y_cnt     [4];
    logic [YW-1:0]   y_next    [4];
    logic [GW-1:0]   g_cnt     [4];
    logic [GW-1:0]   g_next    [4];
    logic            fault_q;
    logic [2:0]      code_q;
    logic            blink_q;
    logic [BW-1:0]   blink_cnt;

    logic            axis_a_active;
    logic            axis_b_active;
    logic            conflict;
    logic            illegal;
    logic            bad_seq;
    logic            short_yellow;
    logic            stuck_green;
    logic            all_red;
    logic            violation;
    logic [2:0]      cause;

    // A signal is active when it shows yellow or green; 11 never counts as active.
    function automatic logic is_active(input logic [1:0] code);
        return (code == LAMP_YELLOW) || (code == LAMP_GREEN);
    endfunction

    assign in_code[0] = bus.NS_IN;
    assign in_code[1] = bus.SN_IN;
    assign in_code[2] = bus.EW_IN;
    assign in_code[3] = bus.WE_IN;

    assign bus.NS         = lamp_q[0];
    assign bus.SN         = lamp_q[1];
    assign bus.EW         = lamp_q[2];
    assign bus.WE         = lamp_q[3];
    assign bus.FAULT      = fault_q;
    assign bus.FAULT_CODE = code_q;
    assign bus.BLINK      = blink_q;

    // Evaluate all checks on the current inputs and the next colour-run counts.
    always_comb begin
        axis_a_active = is_active(in_code[0]) || is_active(in_code[1]);
        axis_b_active = is_active(in_code[2]) || is_active(in_code[3]);
        conflict      = axis_a_active && axis_b_active;
        illegal       = 1'b0;
        bad_seq       = 1'b0;
        short_yellow  = 1'b0;
        stuck_green   = 1'b0;
        all_red       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            y_next[i] = '0;
            g_next[i] = '0;
            if (in_code[i] == LAMP_BAD) begin
                illegal = 1'b1;
            end
            if (in_code[i] != LAMP_RED) begin
                all_red = 1'b0;
            end
            if (((prev_code[i] == LAMP_GREEN)  && (in_code[i] == LAMP_RED))    ||
                ((prev_code[i] == LAMP_RED)    && (in_code[i] == LAMP_YELLOW)) ||
                ((prev_code[i] == LAMP_YELLOW) && (in_code[i] == LAMP_GREEN))) begin
                bad_seq = 1'b1;
            end
            if ((prev_code[i] == LAMP_YELLOW) && (in_code[i] == LAMP_RED) &&
                (y_cnt[i] < Y_LIMIT)) begin
                short_yellow = 1'b1;
            end
            if ((in_code[i] == LAMP_GREEN) && (g_cnt[i] >= G_LIMIT)) begin
                stuck_green = 1'b1;
            end
            if (in_code[i] == LAMP_YELLOW) begin
                y_next[i] = (y_cnt[i] == Y_LIMIT) ? y_cnt[i] : y_cnt[i] + 1'b1;
            end
            if (in_code[i] == LAMP_GREEN) begin
                g_next[i] = (g_cnt[i] == G_LIMIT) ? g_cnt[i] : g_cnt[i] + 1'b1;
            end
        end

        if (conflict) begin
            cause = CAUSE_CONFLICT;
        end else if (illegal) begin
            cause = CAUSE_ILLEGAL;
        end else if (bad_seq) begin
            cause = CAUSE_SEQUENCE;
        end else if (short_yellow) begin
            cause = CAUSE_SHORT_Y;
        end else if (stuck_green) begin
            cause = CAUSE_STUCK_G;
        end else begin
            cause = CAUSE_NONE;
        end
        violation = (cause != CAUSE_NONE);
    end

    // Monitor state machine: warm-up cycle, pass-through with checking, latched fault.
    always_ff @(posedge CLK) begin
        if (CLEAR) begin
            state     <= ST_INIT;
            fault_q   <= 1'b0;
            code_q    <= CAUSE_NONE;
            blink_q   <= 1'b0;
            blink_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                lamp_q[i]    <= LAMP_RED;
                prev_code[i] <= LAMP_RED;
                y_cnt[i]     <= '0;
                g_cnt[i]     <= '0;
            end
        end else begin
            case (state)
                ST_INIT: begin
                    for (int i = 0; i < 4; i++) begin
                        lamp_q[i]    <= LAMP_RED;
                        prev_code[i] <= in_code[i];
                        y_cnt[i]     <= y_next[i];
                        g_cnt[i]     <= g_next[i];
                    end
                    state <= ST_RUN;
                end

                ST_RUN: begin
                    if (violation) begin
                        state     <= ST_FAULT;
                        fault_q   <= 1'b1;
                        code_q    <= cause;
                        blink_q   <= 1'b1;
                        blink_cnt <= '0;
                        for (int i = 0; i < 4; i++) begin
                            lamp_q[i] <= LAMP_RED;
                        end
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            lamp_q[i]    <= in_code[i];
                            prev_code[i] <= in_code[i];
                            y_cnt[i]     <= y_next[i];
                            g_cnt[i]     <= g_next[i];
                        end
                    end
                end

                ST_FAULT: begin
                    if (bus.FAULT_ACK && all_red) begin
                        state     <= ST_INIT;
                        fault_q   <= 1'b0;
                        code_q    <= CAUSE_NONE;
                        blink_q   <= 1'b0;
                        blink_cnt <= '0;
                        for (int i = 0; i < 4; i++) begin
                            lamp_q[i]    <= LAMP_RED;
                            prev_code[i] <= LAMP_RED;
                            y_cnt[i]     <= '0;
                            g_cnt[i]     <= '0;
                        end
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            lamp_q[i] <= LAMP_RED;
                        end
                        if (blink_cnt == B_LAST) begin
                            blink_cnt <= '0;
                            blink_q   <= ~blink_q;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Testbench for traffic_safety_monitor: a table of hand-computed vectors,
// hand-written sequences for long-run corner cases, and randomized controller
// traffic checked against a run-length based reference model.
module tb_traffic_safety_monitor;

    localparam int MIN_YELLOW = 2;
    localparam int MAX_GREEN  = 16;
    localparam int BLINK_HALF = 4;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic CLK = 1'b0;
    logic CLEAR;

    traffic_safety_monitor_if bus ();

    traffic_safety_monitor #(
        .MIN_YELLOW (MIN_YELLOW),
        .MAX_GREEN  (MAX_GREEN),
        .BLINK_HALF (BLINK_HALF)
    ) dut (
        .CLK   (CLK),
        .CLEAR (CLEAR),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       clr;
        logic [7:0] lampsIn;
        logic       ack;
        logic [7:0] lampsExp;
        logic       faultExp;
        logic [2:0] codeExp;
        logic       blinkExp;
    } vec_t;

    vec_t vecs[$];
    int   nPass  = 0;
    int   nTotal = 0;

    // Reference model state: run lengths are plain unbounded integers.
    bit         mPendingInit;
    bit         mFaulted;
    int         mFaultAge;
    logic [1:0] mLast [4];
    int         mYLen [4];
    int         mGLen [4];
    logic [7:0] expLamps;
    logic [2:0] expCode;

    function automatic logic [7:0] pack4(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c, input logic [1:0] d);
        return {a, b, c, d};
    endfunction

    function automatic bit lit(input logic [1:0] c);
        return (c == Y) || (c == G);
    endfunction

    function automatic logic expBlink();
        return mFaulted && (((mFaultAge / BLINK_HALF) % 2) == 0);
    endfunction

    task automatic addVec(input logic clr, input logic [7:0] lin, input logic ack,
                          input logic [7:0] lexp, input logic f, input logic [2:0] c,
                          input logic b);
        vec_t v;
        v.clr = clr; v.lampsIn = lin; v.ack = ack;
        v.lampsExp = lexp; v.faultExp = f; v.codeExp = c; v.blinkExp = b;
        vecs.push_back(v);
    endtask

    task automatic compareVal(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        nTotal++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic clearRuns();
        for (int i = 0; i < 4; i++) begin
            mLast[i] = R;
            mYLen[i] = 0;
            mGLen[i] = 0;
        end
    endtask

    task automatic advanceRuns(input logic [1:0] c [4]);
        for (int i = 0; i < 4; i++) begin
            mYLen[i] = (c[i] == Y) ? mYLen[i] + 1 : 0;
            mGLen[i] = (c[i] == G) ? mGLen[i] + 1 : 0;
            mLast[i] = c[i];
        end
    endtask

    // One clock edge of the reference model, written from the safety rules.
    task automatic modelStep(input logic clr, input logic [7:0] lamps, input logic ack);
        logic [1:0] c [4];
        bit conflictHit, illegalHit, seqHit, shortHit, stuckHit;
        for (int i = 0; i < 4; i++) c[i] = lamps[7-2*i -: 2];
        expLamps = 8'h00;
        if (clr) begin
            mPendingInit = 1'b1;
            mFaulted     = 1'b0;
            mFaultAge    = 0;
            expCode      = 3'd0;
            clearRuns();
            return;
        end
        if (mFaulted) begin
            if (ack && lamps == 8'h00) begin
                mFaulted     = 1'b0;
                mPendingInit = 1'b1;
                mFaultAge    = 0;
                expCode      = 3'd0;
                clearRuns();
            end else begin
                mFaultAge++;
            end
            return;
        end
        if (mPendingInit) begin
            mPendingInit = 1'b0;
            advanceRuns(c);
            return;
        end
        conflictHit = (lit(c[0]) || lit(c[1])) && (lit(c[2]) || lit(c[3]));
        illegalHit = 0; seqHit = 0; shortHit = 0; stuckHit = 0;
        for (int i = 0; i < 4; i++) begin
            if (c[i] == X) illegalHit = 1;
            if ((mLast[i] == G && c[i] == R) || (mLast[i] == R && c[i] == Y) ||
                (mLast[i] == Y && c[i] == G)) seqHit = 1;
            if (mLast[i] == Y && c[i] == R && mYLen[i] < MIN_YELLOW) shortHit = 1;
            if (c[i] == G && mGLen[i] + 1 >= MAX_GREEN + 1) stuckHit = 1;
        end
        if (conflictHit || illegalHit || seqHit || shortHit || stuckHit) begin
            mFaulted  = 1'b1;
            mFaultAge = 0;
            expCode   = conflictHit ? 3'd1 : illegalHit ? 3'd2 : seqHit ? 3'd3 :
                        shortHit ? 3'd4 : 3'd5;
        end else begin
            expLamps = lamps;
            advanceRuns(c);
        end
    endtask

    // Drive one cycle of inputs, take the clock edge, then advance the model.
    task automatic applyStimulus(input logic clr, input logic [7:0] lamps, input logic ack);
        CLEAR         = clr;
        bus.NS_IN     = lamps[7:6];
        bus.SN_IN     = lamps[5:4];
        bus.EW_IN     = lamps[3:2];
        bus.WE_IN     = lamps[1:0];
        bus.FAULT_ACK = ack;
        @(posedge CLK);
        #1;
        modelStep(clr, lamps, ack);
    endtask

    // Compare every DUT output against the reference model.
    task automatic checkOutput(input string tag);
        compareVal({tag, ".lamps"}, {24'd0, bus.NS, bus.SN, bus.EW, bus.WE}, {24'd0, expLamps});
        compareVal({tag, ".fault"}, {31'd0, bus.FAULT}, {31'd0, mFaulted});
        compareVal({tag, ".code"},  {29'd0, bus.FAULT_CODE}, {29'd0, expCode});
        compareVal({tag, ".blink"}, {31'd0, bus.BLINK}, {31'd0, expBlink()});
    endtask

    logic [1:0] plan [4];

    initial begin
        CLEAR = 1'b1;
        bus.NS_IN = R; bus.SN_IN = R; bus.EW_IN = R; bus.WE_IN = R;
        bus.FAULT_ACK = 1'b0;
        mPendingInit = 1'b1; mFaulted = 1'b0; mFaultAge = 0;
        expLamps = 8'h00; expCode = 3'd0;
        clearRuns();

        // ---------------- table-driven vectors ----------------
        addVec(1, pack4(R,R,R,R), 0, 8'h00,            0, 3'd0, 0);
        addVec(1, pack4(R,R,R,R), 0, 8'h00,            0, 3'd0, 0);
        addVec(0, pack4(G,G,R,R), 0, 8'h00,            0, 3'd0, 0);
        addVec(0, pack4(G,G,R,R), 0, pack4(G,G,R,R),   0, 3'd0, 0);
        addVec(0, pack4(Y,Y,R,R), 0, pack4(Y,Y,R,R),   0, 3'd0, 0);
        addVec(0, pack4(Y,Y,R,R), 0, pack4(Y,Y,R,R),   0, 3'd0, 0);
        addVec(0, pack4(R,R,R,R), 0, pack4(R,R,R,R),   0, 3'd0, 0);
        addVec(0, pack4(R,R,G,G), 0, pack4(R,R,G,G),   0, 3'd0, 0);
        addVec(0, pack4(G,G,G,G), 0, 8'h00,            1, 3'd1, 1);
        addVec(0, pack4(G,G,G,G), 1, 8'h00,            1, 3'd1, 1);
        addVec(0, pack4(R,R,R,R), 1, 8'h00,            0, 3'd0, 0);
        addVec(0, pack4(R,R,R,R), 0, 8'h00,            0, 3'd0, 0);
        addVec(0, pack4(G,G,R,R), 0, pack4(G,G,R,R),   0, 3'd0, 0);
        addVec(0, pack4(R,G,R,X), 0, 8'h00,            1, 3'd2, 1);
        addVec(1, pack4(R,R,R,R), 0, 8'h00,            0, 3'd0, 0);
        addVec(0, pack4(R,R,R,R), 0, 8'h00,            0, 3'd0, 0);
        addVec(0, pack4(R,G,R,R), 0, pack4(R,G,R,R),   0, 3'd0, 0);
        addVec(0, pack4(R,Y,R,R), 0, pack4(R,Y,R,R),   0, 3'd0, 0);
        addVec(0, pack4(R,R,R,R), 0, 8'h00,            1, 3'd4, 1);
        addVec(0, pack4(R,R,R,R), 0, 8'h00,            1, 3'd4, 1);
        addVec(0, pack4(R,R,R,R), 0, 8'h00,            1, 3'd4, 1);
        addVec(0, pack4(R,R,R,R), 0, 8'h00,            1, 3'd4, 1);
        addVec(0, pack4(R,R,R,R), 0, 8'h00,            1, 3'd4, 0);
        addVec(0, pack4(R,R,R,R), 1, 8'h00,            0, 3'd0, 0);
        addVec(0, pack4(R,R,R,R), 0, 8'h00,            0, 3'd0, 0);
        addVec(0, pack4(R,R,R,R), 1, 8'h00,            0, 3'd0, 0);
        addVec(0, pack4(R,R,R,Y), 0, 8'h00,            1, 3'd3, 1);
        addVec(0, pack4(R,R,R,R), 0, 8'h00,            1, 3'd3, 1);
        addVec(1, pack4(R,R,R,R), 0, 8'h00,            0, 3'd0, 0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].clr, vecs[k].lampsIn, vecs[k].ack);
            compareVal($sformatf("vec%0d.lamps", k), {24'd0, bus.NS, bus.SN, bus.EW, bus.WE},
                       {24'd0, vecs[k].lampsExp});
            compareVal($sformatf("vec%0d.fault", k), {31'd0, bus.FAULT}, {31'd0, vecs[k].faultExp});
            compareVal($sformatf("vec%0d.code", k), {29'd0, bus.FAULT_CODE}, {29'd0, vecs[k].codeExp});
            compareVal($sformatf("vec%0d.blink", k), {31'd0, bus.BLINK}, {31'd0, vecs[k].blinkExp});
        end

        // ---------------- 16 greens then yellow is legal ----------------
        applyStimulus(0, pack4(R,R,R,R), 0);
        for (int k = 0; k < MAX_GREEN; k++) begin
            applyStimulus(0, pack4(R,R,G,R), 0);
            checkOutput($sformatf("green16_%0d", k));
        end
        applyStimulus(0, pack4(R,R,Y,R), 0);
        applyStimulus(0, pack4(R,R,Y,R), 0);
        applyStimulus(0, pack4(R,R,R,R), 0);
        compareVal("green16.no_fault", {31'd0, bus.FAULT}, 32'd0);

        // ---------------- 17 greens trips the watchdog ----------------
        for (int k = 0; k < MAX_GREEN + 1; k++) begin
            applyStimulus(0, pack4(R,R,G,R), 0);
            if (k < MAX_GREEN) begin
                compareVal($sformatf("green17_%0d.fault", k), {31'd0, bus.FAULT}, 32'd0);
            end
        end
        compareVal("green17.fault", {31'd0, bus.FAULT}, 32'd1);
        compareVal("green17.code", {29'd0, bus.FAULT_CODE}, 32'd5);
        compareVal("green17.lamps", {24'd0, bus.NS, bus.SN, bus.EW, bus.WE}, 32'd0);

        // ---------------- blink period in FAULT ----------------
        for (int k = 1; k <= 4 * BLINK_HALF; k++) begin
            applyStimulus(0, pack4(R,R,R,R), 0);
            compareVal($sformatf("blink_age%0d", k), {31'd0, bus.BLINK},
                       {31'd0, ((k / BLINK_HALF) % 2) == 0});
        end

        // ---------------- acknowledge rules ----------------
        applyStimulus(0, pack4(G,R,R,R), 1);
        compareVal("ack_nonred.fault", {31'd0, bus.FAULT}, 32'd1);
        compareVal("ack_nonred.code", {29'd0, bus.FAULT_CODE}, 32'd5);
        applyStimulus(0, pack4(R,R,R,R), 1);
        checkOutput("ack_red");
        compareVal("ack_red.fault", {31'd0, bus.FAULT}, 32'd0);
        compareVal("ack_red.code", {29'd0, bus.FAULT_CODE}, 32'd0);
        applyStimulus(0, pack4(G,G,R,R), 1);
        compareVal("init_after_ack.lamps", {24'd0, bus.NS, bus.SN, bus.EW, bus.WE}, 32'd0);
        applyStimulus(0, pack4(G,G,R,R), 0);
        compareVal("run_after_ack.lamps", {24'd0, bus.NS, bus.SN, bus.EW, bus.WE},
                   {24'd0, pack4(G,G,R,R)});
        compareVal("run_after_ack.fault", {31'd0, bus.FAULT}, 32'd0);

        // ---------------- randomized controller traffic ----------------
        applyStimulus(1, pack4(R,R,R,R), 0);
        for (int i = 0; i < 4; i++) plan[i] = R;
        for (int n = 0; n < 1500; n++) begin
            logic ack;
            logic clr;
            clr = ($urandom_range(0, 99) == 0);
            if (mFaulted) begin
                if ($urandom_range(0, 9) < 6) begin
                    for (int i = 0; i < 4; i++) plan[i] = R;
                end
                ack = ($urandom_range(0, 2) == 0);
            end else begin
                ack = ($urandom_range(0, 19) == 0);
                for (int i = 0; i < 4; i++) begin
                    int r;
                    r = $urandom_range(0, 99);
                    if (r < 3) begin
                        plan[i] = 2'($urandom_range(0, 3));
                    end else if (r >= 75) begin
                        case (plan[i])
                            R: begin
                                if ((i < 2 && plan[2] == R && plan[3] == R) ||
                                    (i >= 2 && plan[0] == R && plan[1] == R)) plan[i] = G;
                            end
                            G:       plan[i] = Y;
                            default: plan[i] = R;
                        endcase
                    end
                end
            end
            applyStimulus(clr, pack4(plan[0], plan[1], plan[2], plan[3]), ack);
            checkOutput($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/traffic_safety_monitor.md
Name: traffic_safety_monitor

Overview:
- Sits directly downstream of the 4-signal traffic light controller, between its NS/SN/EW/WE state outputs and the lamp drivers.
- Registers the four 2-bit lamp codes through to the lamp outputs.
- Checks every cycle for conflicting greens, illegal codes, illegal colour sequences, short yellows and stuck greens.
- On any violation, latches a fault, forces all lamps red with a blink enable, and stays there until an acknowledge arrives while the controller shows all-red.

Parameters:
MIN_YELLOW, 2, minimum consecutive cycles a signal must stay yellow before going red (>=1)
MAX_GREEN, 16, maximum consecutive cycles a signal may stay green (>=2)
BLINK_HALF, 4, half-period of BLINK in cycles during FAULT (>=1)

Ports:
CLK  input  1  system clock, rising edge
CLEAR  input  1  synchronous active-high reset
NS_IN  input  2  controller lamp code, north-south
SN_IN  input  2  controller lamp code, south-north
EW_IN  input  2  controller lamp code, east-west
WE_IN  input  2  controller lamp code, west-east
FAULT_ACK  input  1  single-cycle fault acknowledge
NS  output  2  lamp drive, north-south
SN  output  2  lamp drive, south-north
EW  output  2  lamp drive, east-west
WE  output  2  lamp drive, west-east
FAULT  output  1  fault latched
FAULT_CODE  output  3  cause of first fault
BLINK  output  1  lamp blink enable (FAULT only)

Behaviour:
- Interface: one clock, CLK; reset CLEAR is synchronous and active-high.
- Lamp encoding: 00 red, 01 yellow, 10 green, 11 illegal.
- Axis A = {NS, SN}; axis B = {EW, WE}.
- A signal is "active" when its code is yellow or green.
- Reset (CLEAR high at an edge): state INIT; NS/SN/EW/WE=00; FAULT=0; FAULT_CODE=000; BLINK=0; all counters and previous-code registers cleared to red/0. CLEAR mid-operation, including in FAULT, returns to this state at the next edge.
- States:
  - INIT: lasts exactly one cycle after CLEAR falls. Outputs stay red, inputs are captured into the previous-code registers, no checks run. Next state is RUN.
  - RUN: each edge, outputs <= inputs (1-cycle latency), checks are evaluated on the current inputs against the previous-code registers, and previous <= inputs.
  - FAULT: entered at the same edge a check fails. That edge loads 00 on all outputs, so the offending codes never reach the lamps. FAULT=1; FAULT_CODE is latched and held.
- Checks, with priority when several fire in one cycle (lowest code wins):
  - 001 conflict: any axis-A signal active while any axis-B signal is active. NS with SN, or EW with WE, is legal.
  - 010 illegal code: any input equals 11.
  - 011 bad sequence: any signal does green->red, red->yellow or yellow->green. Legal transitions are R->G, G->Y, Y->R and hold.
  - 100 short yellow: a signal goes Y->R after fewer than MIN_YELLOW consecutive yellow cycles.
  - 101 stuck green: a signal's consecutive green count reaches MAX_GREEN + 1 (watchdog).
- Counters: one yellow counter and one green counter per signal.
  - Each saturates at its limit.
  - Each clears on the cycle its colour is left.
  - The count includes the current cycle, so a signal with MIN_YELLOW=2 that is yellow for 2 cycles and then red is legal.
- BLINK in FAULT: toggles every BLINK_HALF cycles, starting at 1 on the first FAULT cycle. BLINK is 0 outside FAULT.
- FAULT exit: FAULT_ACK=1 at an edge while all four inputs are 00. That edge moves to INIT, clears FAULT, FAULT_CODE, BLINK and all counters. FAULT_ACK with any input non-red is ignored, and the fault stays latched. FAULT_ACK in RUN or INIT has no effect.
- Entry into FAULT takes precedence over everything except CLEAR.

Test Plan:
- CLEAR high for 2 edges, then legal cycle NS/SN=G×5, Y×2, R; EW/WE=R then G×5, Y×2 -> outputs equal inputs delayed by 1 cycle; FAULT stays 0 for 40 cycles.
- RUN with NS=10 and EW=10 in the same cycle -> next edge: all outputs 00, FAULT=1, FAULT_CODE=001, BLINK=1; BLINK period 8 cycles at BLINK_HALF=4.
- In the same cycle, WE=11 and NS goes G->R -> FAULT_CODE=010 (priority over 011).
- SN yellow for 1 cycle then red (MIN_YELLOW=2) -> FAULT_CODE=100. Separately, EW green for 17 consecutive cycles -> fault on the 17th green cycle with FAULT_CODE=101; 16 green cycles then yellow -> no fault.
- In FAULT, FAULT_ACK pulse while NS_IN=10 -> stays FAULT. FAULT_ACK pulse with all inputs 00 -> INIT next cycle, then RUN; FAULT=0, FAULT_CODE=000.
- CLEAR asserted for one edge while in FAULT with BLINK=1 -> next cycle INIT, all outputs 00, FAULT=0, BLINK=0.
